// File: rtl/vector_addsub_flex_if.sv
// Operand/result bundle for the vector add/subtract block.
interface vector_addsub_flex_if #(
    parameter int unsigned LBUF = 128
);
    logic                 start;
    logic                 sub;
    logic [31:0]          l;
    logic [32*LBUF-1:0]   A;
    logic [32*LBUF-1:0]   B;
    logic [32*LBUF-1:0]   result;
    logic                 busy;
    logic                 done;

    modport master (
        output start, sub, l, A, B,
        input  result, busy, done
    );

    modport slave (
        input  start, sub, l, A, B,
        output result, busy, done
    );
endinterface

// File: rtl/vector_addsub_flex.sv
// Element-wise single-precision add/subtract over a runtime-length vector,
// LANES elements per clock, with operand capture and start/busy/done handshake.
module vector_addsub_flex #(
    parameter int unsigned LBUF  = 128,
    parameter int unsigned LANES = 4
) (
    input  logic               clk,
    input  logic               rst,
    vector_addsub_flex_if.slave bus
);
    localparam int unsigned IdxW = $clog2(LBUF);
    localparam int unsigned CntW = $clog2(LBUF + 1);

    if (LBUF % LANES != 0) begin : g_bad_lanes
        $error("LBUF must be a multiple of LANES");
    end

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic [31:0]       a_q [LBUF];
    logic [31:0]       a_d [LBUF];
    logic [31:0]       b_q [LBUF];
    logic [31:0]       b_d [LBUF];
    logic [31:0]       res_q [LBUF];
    logic [31:0]       res_d [LBUF];
    logic              sub_q, sub_d;
    logic [CntW-1:0]   leff_q, leff_d;
    logic [CntW-1:0]   base_q, base_d;
    logic [CntW-1:0]   l_clamp;
    logic [CntW-1:0]   idx;
    logic              accept;
    logic              last_group;

    // IEEE-754 single add, round-to-nearest-even, subnormals supported.
    function automatic logic [31:0] fp_add(input logic [31:0] x, input logic [31:0] y);
        logic [31:0] a, b;
        logic [9:0]  ea, eb, e, d;
        logic [26:0] ma, mb, mbs, mask;
        logic [27:0] s;
        logic        inc;
        logic [24:0] r;
        // Larger magnitude goes to a; it fixes the result sign and exponent.
        if (x[30:0] < y[30:0]) begin
            a = y;
            b = x;
        end else begin
            a = x;
            b = y;
        end
        if (a[30:23] == 8'hFF) begin
            if (a[22:0] != 23'd0 || (b[30:0] == a[30:0] && a[31] != b[31])) begin
                return 32'h7FC0_0000;
            end
            return a;
        end
        ea = (a[30:23] == 8'd0) ? 10'd1 : {2'b00, a[30:23]};
        eb = (b[30:23] == 8'd0) ? 10'd1 : {2'b00, b[30:23]};
        ma = {a[30:23] != 8'd0, a[22:0], 3'b000};
        mb = {b[30:23] != 8'd0, b[22:0], 3'b000};
        d  = ea - eb;
        // Align b; everything shifted past the round bit collapses into sticky.
        if (d > 10'd26) begin
            mbs = {26'd0, |mb};
        end else begin
            mask = (27'd1 << d) - 27'd1;
            mbs  = (mb >> d) | {26'd0, |(mb & mask)};
        end
        if (a[31] == b[31]) begin
            s = {1'b0, ma} + {1'b0, mbs};
            e = ea;
            if (s[27]) begin
                s = {1'b0, s[27:2], s[1] | s[0]};
                e = ea + 10'd1;
            end
        end else begin
            s = {1'b0, ma} - {1'b0, mbs};
            if (s == 28'd0) begin
                return 32'd0;
            end
            e = ea;
            for (int i = 0; i < 26; i++) begin
                if (!s[26] && e > 10'd1) begin
                    s = s << 1;
                    e = e - 10'd1;
                end
            end
        end
        inc = s[2] & (s[1] | s[0] | s[3]);
        r   = {1'b0, s[26:3]} + {24'd0, inc};
        if (r[24]) begin
            r = {1'b0, r[24:1]};
            e = e + 10'd1;
        end
        if (e >= 10'd255) begin
            return {a[31], 8'hFF, 23'd0};
        end
        return {a[31], r[23] ? e[7:0] : 8'd0, r[22:0]};
    endfunction

    // Handshake decode: accept outside RUN, clamp length, detect final group.
    always_comb begin
        accept     = (state_q != StRun) && bus.start;
        l_clamp    = (bus.l > 32'(LBUF)) ? CntW'(LBUF) : bus.l[CntW-1:0];
        last_group = (32'(base_q) + LANES) >= 32'(leff_q);
    end

    // State register, operand capture and result storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= '{default: '0};
            b_q     <= '{default: '0};
            res_q   <= '{default: '0};
            sub_q   <= 1'b0;
            leff_q  <= '0;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            sub_q   <= sub_d;
            leff_q  <= leff_d;
            base_q  <= base_d;
        end
    end

    // Next-state: zero-length requests complete on the accept edge.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle, StDone: begin
                if (bus.start) begin
                    state_d = (l_clamp == '0) ? StDone : StRun;
                end
            end
            StRun: begin
                if (last_group) begin
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Datapath: latch operands on accept, then write LANES results per RUN cycle.
    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        res_d  = res_q;
        sub_d  = sub_q;
        leff_d = leff_q;
        base_d = base_q;
        idx    = '0;
        if (accept) begin
            for (int i = 0; i < LBUF; i++) begin
                a_d[i]   = bus.A[32*i +: 32];
                b_d[i]   = bus.B[32*i +: 32];
                res_d[i] = 32'd0;
            end
            sub_d  = bus.sub;
            leff_d = l_clamp;
            base_d = '0;
        end else if (state_q == StRun) begin
            for (int k = 0; k < LANES; k++) begin
                idx = base_q + CntW'(k);
                if (idx < leff_q) begin
                    res_d[idx[IdxW-1:0]] = fp_add(a_q[idx[IdxW-1:0]],
                                                  b_q[idx[IdxW-1:0]] ^ {sub_q, 31'd0});
                end
            end
            base_d = base_q + CntW'(LANES);
        end
    end

    // Outputs: status from state, result flattened from storage.
    always_comb begin
        bus.busy   = (state_q == StRun);
        bus.done   = (state_q == StDone);
        bus.result = '0;
        for (int i = 0; i < LBUF; i++) begin
            bus.result[32*i +: 32] = res_q[i];
        end
    end
endmodule

// File: tb/tb_vector_addsub_flex.sv
// Bench for vector_addsub_flex: LBUF=8 with LANES=2, 1 and 8.
module tb_vector_addsub_flex;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    vector_addsub_flex_if #(.LBUF(8)) if2 ();
    vector_addsub_flex_if #(.LBUF(8)) if1 ();
    vector_addsub_flex_if #(.LBUF(8)) if8 ();

    vector_addsub_flex #(.LBUF(8), .LANES(2)) u_dut2 (.clk(clk), .rst(rst), .bus(if2));
    vector_addsub_flex #(.LBUF(8), .LANES(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));
    vector_addsub_flex #(.LBUF(8), .LANES(8)) u_dut8 (.clk(clk), .rst(rst), .bus(if8));

    logic [31:0] va [8];
    logic [31:0] vb [8];

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endfunction

    // Reference: widen to double, add exactly, round once to single (RNE).
    function automatic real f2r(input logic [31:0] f);
        logic [63:0] d;
        if (f[30:0] == 31'd0) return 0.0;
        d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        logic [10:0] e;
        logic [24:0] m;
        logic [28:0] rem;
        logic        up;
        d = $realtobits(r);
        if (d[62:0] == 63'd0) return 32'd0;
        e   = d[62:52] - 11'd896;
        m   = {2'b01, d[51:29]};
        rem = d[28:0];
        up  = (rem > 29'h1000_0000) || (rem == 29'h1000_0000 && m[0]);
        m   = m + 25'(up);
        if (m[24]) begin
            m = m >> 1;
            e = e + 11'd1;
        end
        return {d[63], e[7:0], m[22:0]};
    endfunction

    function automatic logic [31:0] fp_ref(input logic [31:0] a, input logic [31:0] b,
                                           input logic sub);
        return r2f(sub ? f2r(a) - f2r(b) : f2r(a) + f2r(b));
    endfunction

    // Transaction-level model of the LANES=2 instance.
    logic [31:0] m_res [8];
    logic [31:0] m_exp [8];
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    int          m_left = 0;

    always @(posedge clk) begin
        int leff;
        if (rst) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_left <= 0;
            m_res  <= '{default: '0};
        end else if (!m_busy && if2.start) begin
            leff = (if2.l > 32'd8) ? 8 : int'(if2.l);
            for (int i = 0; i < 8; i++) begin
                m_exp[i] <= (i < leff) ? fp_ref(if2.A[32*i +: 32], if2.B[32*i +: 32], if2.sub)
                                       : 32'd0;
            end
            m_res  <= '{default: '0};
            m_done <= (leff == 0);
            m_busy <= (leff != 0);
            m_left <= (leff + 1) / 2;
        end else if (m_busy) begin
            if (m_left == 1) begin
                m_busy <= 1'b0;
                m_done <= 1'b1;
                m_res  <= m_exp;
            end
            m_left <= m_left - 1;
        end
    end

    // Compare every cycle; result is only defined outside RUN.
    always @(negedge clk) begin
        chk("busy", 32'(if2.busy), 32'(m_busy));
        chk("done", 32'(if2.done), 32'(m_done));
        if (!m_busy) begin
            for (int i = 0; i < 8; i++) begin
                chk("result", if2.result[32*i +: 32], m_res[i]);
            end
        end
    end

    task automatic set_ops(input int l, input logic sub);
        if2.l   = 32'(l);
        if2.sub = sub;
        for (int i = 0; i < 8; i++) begin
            if2.A[32*i +: 32] = va[i];
            if2.B[32*i +: 32] = vb[i];
        end
    endtask

    task automatic start_op(input int l, input logic sub, input logic hold);
        @(negedge clk);
        set_ops(l, sub);
        if2.start = 1'b1;
        @(negedge clk);
        if (!hold) if2.start = 1'b0;
    endtask

    task automatic wait_done(output int nb);
        logic fin;
        fin = 1'b0;
        nb  = 0;
        for (int t = 0; t < 40 && !fin; t++) begin
            if (if2.done) begin
                fin       = 1'b1;
                if2.start = 1'b0;
            end else begin
                if (if2.busy) nb++;
                @(negedge clk);
            end
        end
        if (!fin) begin
            checks++;
            errors++;
            $display("FAIL timeout: done got 0 want 1");
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int nb, n1, n8;
        logic f1, f8;
        logic [31:0] ra [8];
        logic [31:0] rb [8];
        if2.start = 0; if2.sub = 0; if2.l = 0; if2.A = '0; if2.B = '0;
        if1.start = 0; if1.sub = 0; if1.l = 0; if1.A = '0; if1.B = '0;
        if8.start = 0; if8.sub = 0; if8.l = 0; if8.A = '0; if8.B = '0;
        repeat (2) @(negedge clk);
        chk("reset busy", 32'(if2.busy), 32'd0);
        chk("reset done", 32'(if2.done), 32'd0);
        chk("reset result0", if2.result[31:0], 32'd0);
        rst = 1'b0;

        // Pin the reference model with hand-derived values.
        chk("ref 1+2", fp_ref(32'h3F80_0000, 32'h4000_0000, 1'b0), 32'h4040_0000);
        chk("ref 3-1", fp_ref(32'h4040_0000, 32'h3F80_0000, 1'b1), 32'h4000_0000);
        chk("ref 1-1", fp_ref(32'h3F80_0000, 32'h3F80_0000, 1'b1), 32'h0000_0000);
        chk("ref tie even", fp_ref(32'h3F80_0000, 32'h3380_0000, 1'b0), 32'h3F80_0000);
        chk("ref round up", fp_ref(32'h3F80_0000, 32'h33C0_0000, 1'b0), 32'h3F80_0001);

        // 1) l=5 add, three busy cycles.
        va = '{default: 32'h3F80_0000};
        vb = '{default: 32'h4000_0000};
        start_op(5, 1'b0, 1'b0);
        wait_done(nb);
        chk("t1 busy cycles", 32'(nb), 32'd3);
        for (int i = 0; i < 8; i++) begin
            chk("t1 elem", if2.result[32*i +: 32], (i < 5) ? 32'h4040_0000 : 32'd0);
        end

        // 2) l=4 subtract, inputs scrambled after accept.
        va = '{default: 32'h4040_0000};
        vb = '{default: 32'h3F80_0000};
        start_op(4, 1'b1, 1'b0);
        if2.A = {8{32'hDEAD_BEEF}};
        if2.B = {8{32'h1234_5678}};
        if2.sub = 1'b0;
        wait_done(nb);
        chk("t2 busy cycles", 32'(nb), 32'd2);
        for (int i = 0; i < 8; i++) begin
            chk("t2 elem", if2.result[32*i +: 32], (i < 4) ? 32'h4000_0000 : 32'd0);
        end

        // 3) zero length, then clamped over-length with rounding corner cases.
        start_op(0, 1'b0, 1'b0);
        chk("t3 l0 done", 32'(if2.done), 32'd1);
        chk("t3 l0 busy", 32'(if2.busy), 32'd0);
        wait_done(nb);
        chk("t3 l0 busy cycles", 32'(nb), 32'd0);
        va = '{32'h3F80_0000, 32'h3FC0_0000, 32'h3F80_0000, 32'h4120_0000,
               32'hC0A0_0000, 32'h3F80_0000, 32'h42C8_0000, 32'h3DCC_CCCD};
        vb = '{32'h3380_0000, 32'h3FC0_0000, 32'h3F80_0000, 32'hC120_0000,
               32'h4020_0000, 32'h33C0_0000, 32'h3DCC_CCCD, 32'h42C8_0000};
        start_op(20, 1'b0, 1'b0);
        wait_done(nb);
        chk("t3 l20 busy cycles", 32'(nb), 32'd4);
        chk("t3 tie even", if2.result[31:0], 32'h3F80_0000);
        chk("t3 1.5+1.5", if2.result[63:32], 32'h4040_0000);
        chk("t3 cancel", if2.result[127:96], 32'h0000_0000);
        chk("t3 -5+2.5", if2.result[159:128], 32'hC020_0000);
        chk("t3 round up", if2.result[191:160], 32'h3F80_0001);

        // 4) start held through RUN, then restart from DONE.
        va = '{default: 32'h3F80_0000};
        vb = '{default: 32'h4000_0000};
        start_op(5, 1'b0, 1'b1);
        wait_done(nb);
        chk("t4 held busy cycles", 32'(nb), 32'd3);
        start_op(6, 1'b1, 1'b0);
        chk("t4 done drop", 32'(if2.done), 32'd0);
        wait_done(nb);
        chk("t4 restart busy cycles", 32'(nb), 32'd3);
        chk("t4 elem0", if2.result[31:0], 32'hBF80_0000);
        chk("t4 elem6", if2.result[223:192], 32'd0);

        // 5) reset during the second RUN cycle.
        start_op(8, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t5 busy", 32'(if2.busy), 32'd0);
        chk("t5 done", 32'(if2.done), 32'd0);
        chk("t5 result", 32'(|if2.result), 32'd0);
        start_op(8, 1'b0, 1'b0);
        wait_done(nb);
        chk("t5 busy cycles", 32'(nb), 32'd4);
        chk("t5 elem7", if2.result[255:224], 32'h4040_0000);

        // 6) LANES=1 and LANES=8 on random normal operands.
        for (int p = 0; p < 2; p++) begin
            @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                ra[i] = {1'($urandom), 8'(120 + $urandom_range(0, 14)), 23'($urandom)};
                rb[i] = {1'($urandom), 8'(120 + $urandom_range(0, 14)), 23'($urandom)};
                if1.A[32*i +: 32] = ra[i];
                if1.B[32*i +: 32] = rb[i];
                if8.A[32*i +: 32] = ra[i];
                if8.B[32*i +: 32] = rb[i];
            end
            if1.l = 32'd8; if8.l = 32'd8;
            if1.sub = 1'(p); if8.sub = 1'(p);
            if1.start = 1'b1; if8.start = 1'b1;
            @(negedge clk);
            if1.start = 1'b0; if8.start = 1'b0;
            f1 = 1'b0; f8 = 1'b0; n1 = 0; n8 = 0;
            for (int t = 0; t < 40 && !(f1 && f8); t++) begin
                if (!f1) begin
                    if (if1.done) f1 = 1'b1;
                    else if (if1.busy) n1++;
                end
                if (!f8) begin
                    if (if8.done) f8 = 1'b1;
                    else if (if8.busy) n8++;
                end
                if (!(f1 && f8)) @(negedge clk);
            end
            chk("t6 lanes1 done", 32'(f1), 32'd1);
            chk("t6 lanes8 done", 32'(f8), 32'd1);
            chk("t6 lanes1 latency", 32'(n1), 32'd8);
            chk("t6 lanes8 latency", 32'(n8), 32'd1);
            for (int i = 0; i < 8; i++) begin
                chk("t6 lanes1 elem", if1.result[32*i +: 32], fp_ref(ra[i], rb[i], 1'(p)));
                chk("t6 lanes8 elem", if8.result[32*i +: 32], fp_ref(ra[i], rb[i], 1'(p)));
            end
        end

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
